// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and constants for the count sequencer
// Purpose: FSM state encoding and default count width, shared by all count_sequencer files.
// Ports: none (package).
package count_pkg;

   localparam int WIDTH_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - control/status bundle of the count sequencer
// Purpose: groups run control inputs and count/status outputs.
// Ports: start, pause, abort, start_val, end_val (master -> slave);
//        q, busy, done (slave -> master).
interface count_sequencer_if
   import count_pkg::*;
   #(parameter int WIDTH = WIDTH_DEF);

   logic             start;
   logic             pause;
   logic             abort;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] end_val;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;

   modport master (
      output start, pause, abort, start_val, end_val,
      input  q, busy, done
   );

   modport slave (
      input  start, pause, abort, start_val, end_val,
      output q, busy, done
   );

endinterface

// File: rtl/count_reg.sv
// rtl/count_reg.sv - loadable wrapping up-counter register
// Purpose: count register with clear > load > increment priority; wraps modulo 2^WIDTH.
// Ports: clk, reset (async active-low), clr, load, en, d (load value), q (count).
module count_reg
   import count_pkg::*;
   #(parameter int WIDTH = WIDTH_DEF)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = d;
      end else if (en) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - start/pause/abort controlled count sequencer
// Purpose: counts from a captured start value to a captured end value (wrapping),
//          pulses done on terminal count. Macro COUNT_SEQUENCER_AUTORELOAD_EN makes
//          terminal count reload the captured start value and keep running.
// Ports: clk, reset (async active-low), bus (count_sequencer_if.slave:
//        start, pause, abort, start_val, end_val in; q, busy, done out).
module count_sequencer
   import count_pkg::*;
   #(parameter int WIDTH = WIDTH_DEF)
(
   input  logic               clk,
   input  logic               reset,
   count_sequencer_if.slave   bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] end_q, end_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] load_val;
   logic             clr, load, en;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d  = state_q;
      end_d    = end_q;
      done_d   = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      en       = 1'b0;
      load_val = bus.start_val;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
      reload_d = reload_q;
`endif
      // abort outranks every other input in every state
      if (bus.abort) begin
         state_d = IDLE;
         clr     = 1'b1;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  load    = 1'b1;
                  end_d   = bus.end_val;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
                  reload_d = bus.start_val;
`endif
                  state_d = RUN;
               end
            end
            RUN: begin
               // pause is checked before the terminal compare
               if (bus.pause) begin
                  state_d = HOLD;
               end else if (count == end_q) begin
                  done_d = 1'b1;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
                  load     = 1'b1;
                  load_val = reload_q;
`else
                  state_d  = DONE;
`endif
               end else begin
                  en = 1'b1;
               end
            end
            HOLD: begin
               // resume costs one edge with no increment
               if (!bus.pause) begin
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         end_q    <= '0;
         done_q   <= 1'b0;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         end_q    <= end_d;
         done_q   <= done_d;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   count_reg #(.WIDTH(WIDTH)) u_count_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .load  (load),
      .en    (en),
      .d     (load_val),
      .q     (count)
   );

   assign bus.q    = count;
   assign bus.busy = (state_q == RUN) || (state_q == HOLD);
   assign bus.done = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer
module tb_count_sequencer;

   localparam int W = 7;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   count_sequencer_if #(.WIDTH(W)) bus ();

   count_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int q;
      bit busy;
      bit done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // reference model: abstract run/hold flags and integer count
   bit m_active, m_held, m_done;
   int m_q, m_end, m_start;

   function automatic void model_reset();
      m_active = 0;
      m_held   = 0;
      m_done   = 0;
      m_q      = 0;
      m_end    = 0;
      m_start  = 0;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      if (!reset) begin
         model_reset();
      end else begin
         m_done = 0;
         if (bus.abort) begin
            m_active = 0;
            m_held   = 0;
            m_q      = 0;
         end else if (!m_active) begin
            if (bus.start) begin
               m_q      = int'(bus.start_val);
               m_end    = int'(bus.end_val);
               m_start  = int'(bus.start_val);
               m_active = 1;
               m_held   = 0;
            end
         end else if (m_held) begin
            if (!bus.pause) m_held = 0;
         end else if (bus.pause) begin
            m_held = 1;
         end else if (m_q == m_end) begin
            m_done = 1;
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
            m_q = m_start;
`else
            m_active = 0;
`endif
         end else begin
            m_q = (m_q + 1) % (1 << W);
         end
      end
      e.q    = m_q;
      e.busy = m_active;
      e.done = m_done;
      exp_q.push_back(e);
   end

   // monitor: compares the DUT state settled after each edge
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (int'(bus.q) == e.q && bus.busy == e.busy && bus.done == e.done) begin
            n_pass++;
         end else begin
            $display("FAIL scoreboard t=%0t got q=%0d busy=%0b done=%0b required q=%0d busy=%0b done=%0b",
                     $time, bus.q, bus.busy, bus.done, e.q, e.busy, e.done);
         end
      end
   end

   task automatic chk(input string nm, input int got, input int req);
      n_checks++;
      if (got == req) n_pass++;
      else $display("FAIL %s got=%0d required=%0d", nm, got, req);
   endtask

   task automatic drive(input bit s, input bit p, input bit a, input int sv, input int ev);
      @(negedge clk);
      #1;
      bus.start     = s;
      bus.pause     = p;
      bus.abort     = a;
      bus.start_val = W'(sv);
      bus.end_val   = W'(ev);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_q"}, int'(bus.q), 0);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
   endtask

   initial begin
      bus.start = 0; bus.pause = 0; bus.abort = 0;
      bus.start_val = '0; bus.end_val = '0;
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1 check_reset_state("reset_init");
      repeat (2) @(negedge clk);

      // release with start sampled on the first edge: 3..6 then done
      #1;
      reset = 1'b1;
      bus.start = 1; bus.start_val = W'(3); bus.end_val = W'(6);
      idle(7);

      // wrap through 127 -> 0 to end_val 1
      drive(1, 0, 0, 126, 1);
      idle(6);

      // start_val == end_val: done on the edge after acceptance
      drive(1, 0, 0, 9, 9);
      idle(3);

      // pause for 3 cycles at q=10, plus an ignored start mid-run
      drive(1, 0, 0, 8, 20);
      idle(2);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
      idle(2);
      drive(1, 0, 0, 50, 60);
      idle(12);

      // abort together with start while q=20
      drive(1, 0, 0, 15, 40);
      idle(5);
      drive(1, 0, 1, 5, 9);
      idle(2);

      // asynchronous reset between edges during a run
      drive(1, 0, 0, 0, 100);
      idle(3);
      @(posedge clk);
      #2;
      reset = 1'b0;
      exp_q.delete();
      model_reset();
      #1 check_reset_state("reset_async");
      @(negedge clk);
      #1;
      reset = 1'b1;
      bus.start = 1; bus.start_val = W'(5); bus.end_val = W'(7);
      idle(6);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int sv;
         int ev;
         sv = int'($urandom_range(0, (1 << W) - 1));
         ev = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << W) - 1))
                                          : (sv + int'($urandom_range(0, 9))) % (1 << W);
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 39) == 0), sv, ev);
      end

      idle(2);
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 7, count register width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge active.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a count run; sampled each rising edge.
REQ-005 SHALL have port: pause  input  1  hold count while high during a run.
REQ-006 SHALL have port: abort  input  1  terminate the run and return to idle.
REQ-007 SHALL have port: start_val  input  WIDTH  first count value; captured on start acceptance.
REQ-008 SHALL have port: end_val  input  WIDTH  terminal count value; captured on start acceptance.
REQ-009 SHALL have port: q  output  WIDTH  current count, registered.
REQ-010 SHALL have port: busy  output  1  high in RUN and HOLD.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when terminal count is reached.

Function
REQ-012 SHALL implement states IDLE, RUN, HOLD and DONE.
REQ-013 SHALL accept start only in IDLE or DONE: at that edge load q<=start_val, latch end_val, and enter RUN.
REQ-014 SHALL ignore start in RUN and HOLD; latched end_val SHALL remain unchanged.
REQ-015 In RUN with pause low and q!=end_val, SHALL increment q by 1 per edge, modulo 2^WIDTH (127->0 wrap for WIDTH=7).
REQ-016 In RUN with q==end_val and pause low, SHALL assert done for exactly one cycle, hold q, and enter DONE.
REQ-017 In RUN with pause high, SHALL enter HOLD with q unchanged; pause takes priority over terminal detection.
REQ-018 In HOLD, SHALL keep q; when pause is low, SHALL return to RUN with no increment on that edge.
REQ-019 abort high at any edge SHALL force IDLE, set q=0, and leave done low; abort SHALL have priority over start and pause.
REQ-020 start_val==end_val SHALL produce done on the edge after acceptance, with no increment.
REQ-021 end_val<start_val SHALL count through the wrap to end_val, not stop early.
REQ-022 In DONE, SHALL hold q and keep busy low until a start or abort.

Reset
REQ-023 reset low SHALL immediately force IDLE, q=0, busy=0, done=0, and latched end_val=0, regardless of clk.
REQ-024 On reset deassertion, SHALL first act on the next rising edge; a start sampled at that edge SHALL be accepted.

Configuration
REQ-025 SHALL use macro COUNT_SEQUENCER_AUTORELOAD_EN to select auto-reload behaviour.
REQ-026 When COUNT_SEQUENCER_AUTORELOAD_EN is defined, terminal count SHALL pulse done, reload q<=start_val (value captured at acceptance), and remain in RUN; only abort or reset SHALL end the run.
REQ-027 When COUNT_SEQUENCER_AUTORELOAD_EN is undefined, behaviour SHALL follow REQ-016 and DONE.

Structure
REQ-028 SHALL place the state enum (IDLE/RUN/HOLD/DONE) and the default WIDTH constant in the shared package count_pkg.
REQ-029 SHALL instantiate the count register as sub-module count_reg, with ports clk, reset, clr, load, en, d, and q.
REQ-030 SHALL implement the FSM and terminal compare in count_sequencer only.

Verification
REQ-031 Scenario: start_val=3, end_val=6, start pulse at edge k -> q=3,4,5,6 after edges k..k+3; done=1 only after edge k+4; q stays 6; busy=0 after edge k+4.
REQ-032 Scenario: start_val=126, end_val=1 -> q=126,127,0,1, then done pulse; no early stop.
REQ-033 Scenario: pause high for 3 cycles while q=10 -> q holds 10 for 3 cycles; after pause drops, q=11 one edge later than the unpaused case.
REQ-034 Scenario: abort asserted together with start while q=20 -> q=0, state IDLE, done=0; start not accepted.
REQ-035 Scenario: reset driven low between clock edges during RUN -> q=0, busy=0 with no clock edge; first start after release counts from start_val.
REQ-036 Scenario: AUTORELOAD_EN defined, start_val=2, end_val=4 -> q=2,3,4,2,3,4...; done pulses on each wrap; busy stays 1.
